// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: sequences the shared 32-bit ALU for MIPS MULTU/DIVU, one step per cycle, owning HI/LO.
// Ports: clk, reset (async, active-high); in_start_1/in_op_2/in_rs_32/in_rt_32 start request;
//   in_ALUResult_32 from the ALU; o_ALUOperation_4/o_A_32/o_B_32/o_shamt_5 drive the ALU;
//   o_busy_1 iteration in progress, o_done_1 completion pulse, o_HI_32/o_LO_32 result registers.
// Build option: define MULDIV_DIV_EN to include DIVU; otherwise only MULTU is accepted.
module alu_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start_1,
  input  logic [1:0]  in_op_2,
  input  logic [31:0] in_rs_32,
  input  logic [31:0] in_rt_32,
  input  logic [31:0] in_ALUResult_32,
  output logic [3:0]  o_ALUOperation_4,
  output logic [31:0] o_A_32,
  output logic [31:0] o_B_32,
  output logic [4:0]  o_shamt_5,
  output logic        o_busy_1,
  output logic        o_done_1,
  output logic [31:0] o_HI_32,
  output logic [31:0] o_LO_32
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic busy_q, busy_d, done_q, done_d;
  logic is_div_op, accept, carry;
`ifdef MULDIV_DIV_EN
  logic [32:0] r33;
  logic ge;
  assign is_div_op = in_op_2 == 2'b01;
  assign r33 = {hi_q, lo_q[31]};
  assign ge = r33 >= {1'b0, m_q};
`else
  assign is_div_op = 1'b0;
`endif
  assign accept = in_start_1 && (state_q == IDLE || state_q == DONE) && (in_op_2 == 2'b00 || is_div_op);
  // ADD wrapped around iff the sum is smaller than an operand
  assign carry = in_ALUResult_32 < hi_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    o_ALUOperation_4 = 4'b0000;
    o_A_32 = '0;
    o_B_32 = '0;
    if (accept) begin
      state_d = is_div_op ? DIV : MUL;
      cnt_d = '0;
      m_d = in_rt_32;
      hi_d = '0;
      lo_d = in_rs_32;
    end else if (state_q == MUL) begin
      o_ALUOperation_4 = ALU_ADD;
      o_A_32 = hi_q;
      o_B_32 = m_q;
      {hi_d, lo_d} = lo_q[0] ? {carry, in_ALUResult_32, lo_q[31:1]} : {1'b0, hi_q, lo_q[31:1]};
      cnt_d = cnt_q + 5'd1;
      state_d = &cnt_q ? DONE : MUL;
`ifdef MULDIV_DIV_EN
    end else if (state_q == DIV) begin
      o_ALUOperation_4 = ALU_SUB;
      o_A_32 = r33[31:0];
      o_B_32 = m_q;
      hi_d = ge ? in_ALUResult_32 : r33[31:0];
      lo_d = {lo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
      state_d = &cnt_q ? DONE : DIV;
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == MUL || state_d == DIV;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign o_shamt_5 = '0;
  assign o_busy_1 = busy_q;
  assign o_done_1 = done_q;
  assign o_HI_32 = hi_q;
  assign o_LO_32 = lo_q;
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer: scoreboard bench for alu_muldiv_sequencer with a behavioural ALU.
module tb_alu_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_start_1 = 1'b0;
  logic [1:0] in_op_2 = 2'b00;
  logic [31:0] in_rs_32 = '0, in_rt_32 = '0, alu_res;
  logic [3:0] o_ALUOperation_4;
  logic [31:0] o_A_32, o_B_32, o_HI_32, o_LO_32;
  logic [4:0] o_shamt_5;
  logic o_busy_1, o_done_1;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; string name;} exp_t;
  exp_t sb[$];

  alu_muldiv_sequencer dut (
    .clk(clk), .reset(reset), .in_start_1(in_start_1), .in_op_2(in_op_2),
    .in_rs_32(in_rs_32), .in_rt_32(in_rt_32), .in_ALUResult_32(alu_res),
    .o_ALUOperation_4(o_ALUOperation_4), .o_A_32(o_A_32), .o_B_32(o_B_32),
    .o_shamt_5(o_shamt_5), .o_busy_1(o_busy_1), .o_done_1(o_done_1),
    .o_HI_32(o_HI_32), .o_LO_32(o_LO_32)
  );

  always #5 clk = ~clk;
  always_comb alu_res = o_ALUOperation_4 == 4'b0011 ? o_A_32 + o_B_32 :
                        o_ALUOperation_4 == 4'b0100 ? o_A_32 - o_B_32 : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && o_done_1) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, o_HI_32, e.hi);
        chk({e.name, "_lo"}, o_LO_32, e.lo);
        chk({e.name, "_busy_at_done"}, {31'd0, o_busy_1}, 32'd0);
      end
    end
  end

  // Entered and left at a negedge; start is sampled at the next posedge.
  task automatic run(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name,
                     input int inject, input int rst_at);
    int n;
    logic [3:0] exp_op;
    exp_op = op == 2'b01 ? 4'b0100 : 4'b0011;
    in_start_1 = 1'b1;
    in_op_2 = op;
    in_rs_32 = rs;
    in_rt_32 = rt;
    if (rst_at == 0) sb.push_back('{exp_hi, exp_lo, name});
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      in_start_1 = n == inject;
      if (n == inject) in_rs_32 = 32'd2;
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        chk({name, "_rst_busy"}, {31'd0, o_busy_1}, 32'd0);
        chk({name, "_rst_done"}, {31'd0, o_done_1}, 32'd0);
        chk({name, "_rst_hi"}, o_HI_32, 32'd0);
        chk({name, "_rst_lo"}, o_LO_32, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (o_done_1) break;
      chk({name, "_busy"}, {31'd0, o_busy_1}, 32'd1);
      chk({name, "_op"}, {28'd0, o_ALUOperation_4}, {28'd0, exp_op});
    end
    chk({name, "_latency"}, n, 32'd33);
  endtask

  task automatic ignored(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    in_start_1 = 1'b1;
    in_op_2 = op;
    in_rs_32 = rs;
    in_rt_32 = rt;
    @(negedge clk);
    in_start_1 = 1'b0;
    repeat (3) begin
      chk({name, "_busy"}, {31'd0, o_busy_1}, 32'd0);
      chk({name, "_op"}, {28'd0, o_ALUOperation_4}, 32'd0);
      @(negedge clk);
    end
    chk({name, "_hi"}, o_HI_32, exp_hi);
    chk({name, "_lo"}, o_LO_32, exp_lo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, o_busy_1}, 32'd0);
    chk("reset_done", {31'd0, o_done_1}, 32'd0);
    chk("reset_hi", o_HI_32, 32'd0);
    chk("reset_lo", o_LO_32, 32'd0);
    chk("reset_alu", {o_ALUOperation_4, o_shamt_5, 23'd0} | o_A_32 | o_B_32, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run(2'b00, 32'd7, 32'd6, 32'd0, 32'h0000002A, "mul7x6", 0, 0);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "mul_max", 0, 0);
`ifdef MULDIV_DIV_EN
    run(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, "div100_7", 0, 0);
    run(2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, "div_max_1", 0, 0);
    run(2'b01, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, "div_by0", 0, 0);
`else
    ignored(2'b01, 32'h1234, 32'd0, 32'hFFFFFFFE, 32'h00000001, "divu_disabled");
`endif
    run(2'b00, 32'h12345678, 32'd9, 32'd0, 32'hA3D70A38, "mul_inject", 10, 0);
    ignored(2'b11, 32'd4, 32'd4, 32'd0, 32'hA3D70A38, "illegal_op");
    run(2'b00, 32'd5, 32'd5, 32'd0, 32'd25, "mul_reset", 0, 20);
    run(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, "mul3x5", 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_sequencer.md
# alu_muldiv_sequencer

Multi-cycle controller that executes MIPS MULTU/DIVU by sequencing the shared 32-bit ALU one step per cycle. It owns the HI/LO registers and drives the ALU's operation, operand and shamt inputs while busy. It sits beside the ALU in the execute stage, muxed onto the ALU inputs by the pipeline control whenever `o_busy_1` is high. It uses only ALU ADD (4'b0011) and SUB (4'b0100); carries and compares are resolved internally.

## Interface
- None: datapath width fixed at 32.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_start_1`  in  1  start request, sampled on the rising edge
- `in_op_2`  in  2  2'b00 MULTU, 2'b01 DIVU, others illegal
- `in_rs_32`  in  32  multiplicand / dividend
- `in_rt_32`  in  32  multiplier / divisor
- `in_ALUResult_32`  in  32  result returned by the ALU
- `o_ALUOperation_4`  out  4  ALU opcode driven to the ALU
- `o_A_32`, `o_B_32`  out  32  ALU operands
- `o_shamt_5`  out  5  constant 0
- `o_busy_1`  out  1  iteration in progress
- `o_done_1`  out  1  one-cycle completion pulse
- `o_HI_32`, `o_LO_32`  out  32  HI/LO registers

## Operation
- States: IDLE, MUL, DIV, DONE. Internal registers: 5-bit counter, 32-bit operand latch M, HI, LO.
- IDLE or DONE with `in_start_1`=1 and a legal op: latch M=`in_rt_32`, HI=0, LO=`in_rs_32` (DIVU: LO=dividend) for MULTU; for DIVU, HI=0, LO=`in_rs_32`. Clear the counter. Enter MUL or DIV.
- Illegal op, or start while in MUL/DIV: ignored, with no state change.
- MUL step: ALU op ADD, A=HI, B=M. carry=(`in_ALUResult_32` < HI). If LO[0]=1, {HI,LO} ← {carry,`in_ALUResult_32`,LO[31:1]}. Otherwise {HI,LO} ← {1'b0,HI,LO[31:1]}.
- DIV step: r33={HI,LO[31]}. ALU op SUB, A=r33[31:0], B=M. If r33 ≥ {1'b0,M}, HI ← `in_ALUResult_32` and LO ← {LO[30:0],1'b1}. Otherwise HI ← r33[31:0] and LO ← {LO[30:0],1'b0}.
- The counter increments each step. After step 31, go to DONE.
- Result: MULTU gives {HI,LO} = 64-bit product. DIVU gives LO=quotient and HI=remainder.
- Divide by zero needs no special case. The algorithm naturally yields LO=32'hFFFFFFFF and HI=dividend.
- In IDLE/DONE, ALU outputs are: op 4'b0000, A=B=0, shamt=0.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, M=HI=LO=0, `o_busy_1`=0, `o_done_1`=0, ALU outputs as for idle.
- Reset asserted mid-operation aborts immediately. No `o_done_1` is produced, and HI/LO read 0.
- Start sampled at edge k: `o_busy_1`=1 from k through edge k+32 (32 step cycles).
- `o_done_1`=1 and `o_busy_1`=0 for exactly the cycle after edge k+32. HI/LO are final from that cycle.
- HI/LO hold until the next accepted start.
- The ALU path is combinational within the cycle. Each step consumes `in_ALUResult_32` in the same cycle it drives A/B/op.
- HI/LO show intermediate values while busy. Consumers must wait for `o_done_1` or for `o_busy_1`=0.
- A start in the DONE cycle is accepted (back-to-back operation), and `o_done_1` still pulses in that cycle.

## Configuration
- `MULDIV_DIV_EN` defined: DIVU (2'b01) is legal, and the DIV state and SUB path are built.
- `MULDIV_DIV_EN` undefined: the DIV state is removed. 2'b01 is illegal and ignored (no busy, no done). `o_ALUOperation_4` is only ever 0000 or 0011.

## Test plan
- MULTU 7×6: done at cycle 33 after start. HI=0, LO=32'h0000002A.
- MULTU 32'hFFFFFFFF×32'hFFFFFFFF: HI=32'hFFFFFFFE, LO=32'h00000001 (exercises carry). During MUL cycles, op=4'b0011 every cycle.
- DIVU 100/7: LO=14, HI=2. Also DIVU 32'hFFFFFFFF/1: LO=32'hFFFFFFFF, HI=0. During DIV cycles, op=4'b0100.
- DIVU 32'h1234/0: LO=32'hFFFFFFFF, HI=32'h1234. Without `MULDIV_DIV_EN`, the same start leaves busy=0, gives no done, and leaves HI/LO unchanged.
- Start pulse at step 10 of a multiply, and illegal op 2'b11 while idle: both ignored. The original result is correct and exactly one done pulse occurs.
- Reset asserted at step 20: busy=0, HI=LO=0 in the same cycle, and no done. A fresh MULTU 3×5 afterwards gives LO=15.
